// File: rtl/rtc_alarm_if.sv
// Bus bundle for the RTC/alarm controller: load, user request and time/alarm status signals.
// The driver side (master) owns the requests; the controller (slave) owns the status.
interface rtc_alarm_if;
   logic       tick;
   logic       ld_time;
   logic       ld_alarm;
   logic [4:0] ld_h;
   logic [5:0] ld_m;
   logic [5:0] ld_s;
   logic       alarm_en;
   logic       snooze;
   logic       stop;
   logic [4:0] h24;
   logic [5:0] m;
   logic [5:0] s;
   logic [3:0] h12;
   logic       pm;
   logic       ringing;
   logic [1:0] alm_state;

   modport master (
      output tick, ld_time, ld_alarm, ld_h, ld_m, ld_s, alarm_en, snooze, stop,
      input  h24, m, s, h12, pm, ringing, alm_state
   );

   modport slave (
      input  tick, ld_time, ld_alarm, ld_h, ld_m, ld_s, alarm_en, snooze, stop,
      output h24, m, s, h12, pm, ringing, alm_state
   );
endinterface

// File: rtl/rtc_alarm_ctrl.sv
// Real-time clock (24h with a 12h view) plus an alarm with snooze and ring timeout.
// State, time and counters share one asynchronous active-high reset.
module rtc_alarm_ctrl #(
   parameter int SNOOZE_MIN = 5,
   parameter int RING_SEC   = 60
) (
   input logic         clk,
   input logic         rst,
   rtc_alarm_if.slave  bus
);
   localparam int SNZ_TOT = SNOOZE_MIN * 60;
   localparam int SW      = $clog2(SNZ_TOT + 2);
   localparam int RW      = $clog2(RING_SEC + 2);
   localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TOT);
   localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [4:0]    h_r, h_nxt, ah_r;
   logic [5:0]    m_r, m_nxt, am_r;
   logic [5:0]    s_r, s_nxt;
   logic [RW-1:0] ring_cnt, ring_nxt;
   logic [SW-1:0] snz_cnt, snz_nxt;
   logic          ringing_r;
   logic          ld_time_ok, ld_alarm_ok, adv, match;

   // An out-of-range load is dropped as if it never happened, so a tick in that cycle still advances.
   assign ld_time_ok  = bus.ld_time && (bus.ld_h <= 5'd23) && (bus.ld_m <= 6'd59) && (bus.ld_s <= 6'd59);
   assign ld_alarm_ok = bus.ld_alarm && (bus.ld_h <= 5'd23) && (bus.ld_m <= 6'd59);
   assign adv         = bus.tick && !ld_time_ok;

   always_comb begin
      h_nxt = h_r;
      m_nxt = m_r;
      s_nxt = s_r;
      if (ld_time_ok) begin
         h_nxt = bus.ld_h;
         m_nxt = bus.ld_m;
         s_nxt = bus.ld_s;
      end else if (adv) begin
         if (s_r == 6'd59) begin
            s_nxt = 6'd0;
            if (m_r == 6'd59) begin
               m_nxt = 6'd0;
               h_nxt = (h_r == 5'd23) ? 5'd0 : h_r + 5'd1;
            end else begin
               m_nxt = m_r + 6'd1;
            end
         end else begin
            s_nxt = s_r + 6'd1;
         end
      end
   end

   // Only a tick rolling onto hh:mm:00 matches; loading that exact time does not.
   assign match = adv && (h_nxt == ah_r) && (m_nxt == am_r) && (s_nxt == 6'd0);

   always_comb begin
      state_nxt = state;
      ring_nxt  = ring_cnt;
      snz_nxt   = snz_cnt;
      case (state)
         IDLE: begin
            if (match) begin
               state_nxt = RING;
               ring_nxt  = '0;
            end
         end
         RING: begin
            if (bus.stop) begin
               state_nxt = IDLE;
               ring_nxt  = '0;
            end else if (bus.snooze) begin
               state_nxt = SNOOZE;
               snz_nxt   = SNZ_LOAD;
               ring_nxt  = '0;
            end else if (bus.tick) begin
               if (ring_cnt == RING_LAST) begin
                  state_nxt = IDLE;
                  ring_nxt  = '0;
               end else begin
                  ring_nxt = ring_cnt + RW'(1);
               end
            end
         end
         SNOOZE: begin
            if (bus.stop) begin
               state_nxt = IDLE;
               snz_nxt   = '0;
            end else if (bus.tick) begin
               if (snz_cnt <= SNZ_ONE) begin
                  state_nxt = RING;
                  ring_nxt  = '0;
                  snz_nxt   = '0;
               end else begin
                  snz_nxt = snz_cnt - SNZ_ONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Disarming beats every other transition.
      if (!bus.alarm_en) begin
         state_nxt = IDLE;
         ring_nxt  = '0;
         snz_nxt   = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         h_r       <= '0;
         m_r       <= '0;
         s_r       <= '0;
         ah_r      <= '0;
         am_r      <= '0;
         ring_cnt  <= '0;
         snz_cnt   <= '0;
         ringing_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         h_r       <= h_nxt;
         m_r       <= m_nxt;
         s_r       <= s_nxt;
         ring_cnt  <= ring_nxt;
         snz_cnt   <= snz_nxt;
         ringing_r <= (state_nxt == RING);
         if (ld_alarm_ok) begin
            ah_r <= bus.ld_h;
            am_r <= bus.ld_m;
         end
      end
   end

   always_comb begin
      bus.pm = (h_r >= 5'd12);
      if (h_r == 5'd0)
         bus.h12 = 4'd12;
      else if (h_r <= 5'd12)
         bus.h12 = h_r[3:0];
      else
         bus.h12 = 4'(h_r - 5'd12);
   end

   assign bus.h24       = h_r;
   assign bus.m         = m_r;
   assign bus.s         = s_r;
   assign bus.ringing   = ringing_r;
   assign bus.alm_state = state;
endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Scoreboard bench for rtc_alarm_ctrl: stimulus queues hand-computed expected outputs,
// a monitor pops and compares them on the falling clock edge.
module tb_rtc_alarm_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   rtc_alarm_if bus();

   rtc_alarm_ctrl #(.SNOOZE_MIN(5), .RING_SEC(60)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [24:0] v;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   function automatic string fmt(logic [24:0] v);
      return $sformatf("%0d:%0d:%0d h12=%0d pm=%0b ring=%0b st=%0d",
                       v[24:20], v[19:14], v[13:8], v[7:4], v[3], v[2], v[1:0]);
   endfunction

   task automatic chk(string n, int h, int mm, int ss, int h12, int pm, int r, int st);
      exp_t e;
      e.name = n;
      e.v    = {5'(h), 6'(mm), 6'(ss), 4'(h12), 1'(pm), 1'(r), 2'(st)};
      q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ldt(int h, int mm, int ss, bit t);
      bus.ld_h = 5'(h); bus.ld_m = 6'(mm); bus.ld_s = 6'(ss);
      bus.ld_time = 1'b1; bus.tick = t;
      cyc();
      bus.ld_time = 1'b0; bus.tick = 1'b0;
   endtask

   task automatic lda(int h, int mm);
      bus.ld_h = 5'(h); bus.ld_m = 6'(mm); bus.ld_s = 6'd0;
      bus.ld_alarm = 1'b1;
      cyc();
      bus.ld_alarm = 1'b0;
   endtask

   task automatic ticks(int n);
      bus.tick = 1'b1;
      repeat (n) cyc();
      bus.tick = 1'b0;
   endtask

   task automatic req(bit sn, bit st);
      bus.snooze = sn; bus.stop = st;
      cyc();
      bus.snooze = 1'b0; bus.stop = 1'b0;
   endtask

   // Monitor: compare everything queued since the last falling edge.
   initial begin
      exp_t        e;
      logic [24:0] act;
      while (!done) begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.h24, bus.m, bus.s, bus.h12, bus.pm, bus.ringing, bus.alm_state};
            checks++;
            if (act !== e.v) begin
               errors++;
               $display("FAIL %s: got %s, want %s", e.name, fmt(act), fmt(e.v));
            end
         end
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin
      bus.tick = 1'b0; bus.ld_time = 1'b0; bus.ld_alarm = 1'b0;
      bus.ld_h = '0; bus.ld_m = '0; bus.ld_s = '0;
      bus.alarm_en = 1'b0; bus.snooze = 1'b0; bus.stop = 1'b0;
      #1;
      chk("reset", 0, 0, 0, 12, 0, 0, 0);
      cyc();
      rst = 1'b0;

      ldt(23, 59, 59, 1'b0); chk("ld_2359", 23, 59, 59, 11, 1, 0, 0);
      ticks(1);              chk("wrap_midnight", 0, 0, 0, 12, 0, 0, 0);
      ldt(24, 0, 0, 1'b0);   chk("bad_h", 0, 0, 0, 12, 0, 0, 0);
      ldt(1, 60, 0, 1'b0);   chk("bad_m", 0, 0, 0, 12, 0, 0, 0);
      ldt(1, 0, 60, 1'b0);   chk("bad_s", 0, 0, 0, 12, 0, 0, 0);
      ldt(13, 5, 0, 1'b0);   chk("h13", 13, 5, 0, 1, 1, 0, 0);
      ldt(12, 0, 0, 1'b0);   chk("noon", 12, 0, 0, 12, 1, 0, 0);
      ldt(3, 4, 5, 1'b1);    chk("ld_over_tick", 3, 4, 5, 3, 0, 0, 0);
      ldt(11, 59, 59, 1'b0);
      ticks(1);              chk("carry_to_noon", 12, 0, 0, 12, 1, 0, 0);

      lda(7, 30);            chk("ld_alarm", 12, 0, 0, 12, 1, 0, 0);
      bus.alarm_en = 1'b1;
      ldt(7, 30, 0, 1'b0);   chk("load_no_match", 7, 30, 0, 7, 0, 0, 0);
      ldt(7, 29, 59, 1'b0);
      ticks(1);              chk("ring_start", 7, 30, 0, 7, 0, 1, 1);
      ticks(59);             chk("ring_59", 7, 30, 59, 7, 0, 1, 1);
      ticks(1);              chk("ring_timeout", 7, 31, 0, 7, 0, 0, 0);

      ldt(7, 29, 59, 1'b0);
      ticks(1);              chk("ring_again", 7, 30, 0, 7, 0, 1, 1);
      req(1'b1, 1'b0);       chk("snooze", 7, 30, 0, 7, 0, 0, 2);
      ticks(299);            chk("snz_299", 7, 34, 59, 7, 0, 0, 2);
      ticks(1);              chk("snz_300", 7, 35, 0, 7, 0, 1, 1);
      req(1'b0, 1'b1);       chk("stop_ring", 7, 35, 0, 7, 0, 0, 0);

      ldt(7, 29, 59, 1'b0);
      ticks(1);
      req(1'b1, 1'b1);       chk("stop_snooze", 7, 30, 0, 7, 0, 0, 0);

      ldt(7, 29, 59, 1'b0);
      ticks(1);
      req(1'b1, 1'b0);
      ticks(10);             chk("snz_10", 7, 30, 10, 7, 0, 0, 2);
      bus.alarm_en = 1'b0;
      cyc();                 chk("en_off", 7, 30, 10, 7, 0, 0, 0);
      ticks(300);            chk("no_ring", 7, 35, 10, 7, 0, 0, 0);

      bus.alarm_en = 1'b1;
      ldt(7, 29, 59, 1'b0);
      ticks(1);
      req(1'b1, 1'b0);
      ticks(5);              chk("snz_5", 7, 30, 5, 7, 0, 0, 2);
      cyc();
      rst = 1'b1;
      #1;                    chk("rst_mid_snooze", 0, 0, 0, 12, 0, 0, 0);
      cyc();
      rst = 1'b0;            chk("rst_release", 0, 0, 0, 12, 0, 0, 0);
      ldt(23, 59, 59, 1'b0);
      ticks(1);              chk("alarm_reset_match", 0, 0, 0, 12, 0, 1, 1);
      req(1'b0, 1'b1);       chk("stop_after_rst", 0, 0, 0, 12, 0, 0, 0);
      ticks(1);              chk("resume", 0, 0, 1, 12, 0, 0, 0);

      cyc();
      done = 1'b1;
   end
endmodule

// File: doc/rtc_alarm_ctrl.md
RTC_ALARM_CTRL -- requirements
Module: rtc_alarm_ctrl

Interface
REQ-001 The block SHALL have parameter SNOOZE_MIN, default 5: snooze length in minutes.
REQ-002 The block SHALL have parameter RING_SEC, default 60: ring timeout in seconds.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all registers are rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: one-cycle 1 Hz advance strobe.
REQ-006 The block SHALL have port ld_time, input, 1 bit: load the time registers from ld_h/ld_m/ld_s.
REQ-007 The block SHALL have port ld_alarm, input, 1 bit: load the alarm registers from ld_h/ld_m (ld_s ignored).
REQ-008 The block SHALL have ports ld_h, ld_m and ld_s, inputs, 5/6/6 bits: load data, 24-hour format.
REQ-009 The block SHALL have port alarm_en, input, 1 bit: alarm arm enable.
REQ-010 The block SHALL have ports snooze and stop, inputs, 1 bit each: user requests, sampled every cycle.
REQ-011 The block SHALL have ports h24, m and s, outputs, 5/6/6 bits: current time.
REQ-012 The block SHALL have ports h12 and pm, outputs, 4 bits and 1 bit: 12-hour view of the current time.
REQ-013 The block SHALL have port ringing, output, 1 bit: alarm active.
REQ-014 The block SHALL have port alm_state, output, 2 bits: IDLE=0, RING=1, SNOOZE=2.

Function
REQ-015 Time counting SHALL follow these rules on each tick: s 0..59 wraps to 0 and carries to m; m 0..59 wraps and carries to h24; h24 0..23 wraps, so 23:59:59 becomes 00:00:00.
REQ-016 ld_time SHALL take priority over tick in the same cycle; the loaded value appears on the next edge and that tick is dropped.
REQ-017 A load SHALL be ignored entirely if any field is out of range (h>23, m>59, or s>59 for ld_time); the same check applies to ld_alarm on h and m.
REQ-018 h12/pm SHALL be combinational from h24 as follows: h24=0 gives 12 am; 1..11 gives the same value am; 12 gives 12 pm; 13..23 gives h24-12 pm.
REQ-019 A match SHALL occur only when a tick (without ld_time) rolls the time to alarm_h:alarm_m:00; a load that lands on that time SHALL NOT match.
REQ-020 IDLE SHALL go to RING on the same edge that updates the time, when match and alarm_en are both true; ringing=1 is then registered together with the new time.
REQ-021 In RING, the ring counter SHALL count ticks; when it reaches RING_SEC the state SHALL go to IDLE.
REQ-022 In RING, stop SHALL send the state to IDLE.
REQ-023 In RING, snooze SHALL send the state to SNOOZE and load the snooze counter with SNOOZE_MIN*60.
REQ-024 In SNOOZE, each tick SHALL decrement the snooze counter; on the tick that reaches 0 the state SHALL go to RING with the ring counter cleared.
REQ-025 In SNOOZE, stop SHALL send the state to IDLE.
REQ-026 When stop and snooze are asserted together, stop SHALL win.
REQ-027 If alarm_en=0 in any state, the state SHALL be IDLE at the next edge; this overrides all other transitions.
REQ-028 A match while in RING or SNOOZE SHALL be ignored.
REQ-029 ld_alarm SHALL update the alarm registers in any state without changing the state.
REQ-030 ld_time during RING or SNOOZE SHALL NOT affect the ring or snooze counters.
REQ-031 ringing SHALL be 1 exactly when alm_state=RING; outputs SHALL be glitch-free, with ringing driven from a register.
REQ-032 Counter widths SHALL cover SNOOZE_MIN*60 and RING_SEC without overflow.

Reset
REQ-033 While rst=1, asynchronously, the block SHALL force h24/m/s=0, alarm=00:00, ring and snooze counters=0, alm_state=IDLE and ringing=0, giving h12=12 and pm=0.
REQ-034 Reset SHALL take effect even mid-RING or mid-SNOOZE, and normal operation SHALL resume on the first edge after rst falls.

Verification
REQ-035 The bench SHALL cover: assert rst mid-SNOOZE -> immediately 00:00:00, h12=12, pm=0, ringing=0, alm_state=0.
REQ-036 The bench SHALL cover: ld_time 23:59:59, then tick -> 00:00:00, h12=12, pm=0; ld_time 24:00:00 -> ignored, time unchanged.
REQ-037 The bench SHALL cover: ld_time 13:05:00 -> h12=1, pm=1; ld_time 12:00:00 -> h12=12, pm=1; ld_time with tick in the same cycle -> loaded value, no increment.
REQ-038 The bench SHALL cover: alarm 07:30, time 07:29:59, alarm_en=1, tick -> time 07:30:00 and ringing=1 on the same edge; 60 more ticks -> ringing=0, IDLE.
REQ-039 The bench SHALL cover: snooze in RING -> SNOOZE, ringing=0; 299 ticks -> still 0; 300th tick -> ringing=1.
REQ-040 The bench SHALL cover: stop+snooze in the same cycle -> IDLE; alarm_en=0 during SNOOZE -> IDLE, with no ring after 300 ticks.
